morse_symbol_shifter: RTL and testbench

Parametrised successor to the 4-bit Morse data register. Accepts a Morse code word plus its symbol length and serialises it one symbol (0=dot, 1=dash) per shift request. Supports LSB-first or MSB-first order, a one-deep pending buffer for back-to-back characters, and explicit done/error reporting. Sits between the character encoder and the Morse timing FSM, which issues shift_i.

---
 rtl/morse_symbol_shifter.sv | 200 ++++++++++++++++++++
 tb/tb_morse_symbol_shifter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/morse_symbol_shifter.sv
// morse_symbol_shifter
//   Serialises a Morse code word, one symbol per shift request
//   (0 = dot, 1 = dash), in LSB-first or MSB-first order. A one-deep
//   pending buffer lets the character encoder queue the next word while
//   the current one is still being sent.
//
//   State | Meaning
//   ------+----------------------------------------------------------
//   IDLE  | no active word; accepts a load straight into the shifter
//   ACTIVE| word being emitted; a load goes to the pending buffer
//
// Ports
//   half_clk   clock, rising edge
//   rst        asynchronous reset, active low
//   code_in    code word, bits at or above len_in ignored
//   len_in     number of valid symbols (0..MAX_SYM)
//   load_i     load request
//   shift_i    shift request from the timing FSM
//   load_rdy   pending buffer empty (combinational, = !pend_v)
//   data       last emitted symbol, held between shifts
//   sym_valid  one-cycle pulse with each update of data
//   new_data   unemitted symbols of the active word
//   count      symbols still to emit
//   busy       high while ACTIVE
//   done       one-cycle pulse when the active word finishes
//   err        one-cycle pulse when a load with an illegal length is seen
module morse_symbol_shifter #(
   parameter int MAX_SYM   = 4,
   parameter int LEN_W     = $clog2(MAX_SYM + 1),
   parameter bit MSB_FIRST = 1'b0
) (
   input  logic               half_clk,
   input  logic               rst,
   input  logic [MAX_SYM-1:0] code_in,
   input  logic [LEN_W-1:0]   len_in,
   input  logic               load_i,
   input  logic               shift_i,
   output logic               load_rdy,
   output logic               data,
   output logic               sym_valid,
   output logic [MAX_SYM-1:0] new_data,
   output logic [LEN_W-1:0]   count,
   output logic               busy,
   output logic               done,
   output logic               err
);

   typedef enum logic {S_IDLE, S_ACTIVE} state_t;

   localparam logic [LEN_W-1:0]   MAX_LEN = LEN_W'(MAX_SYM);
   localparam logic [MAX_SYM-1:0] ONE_HOT = MAX_SYM'(1);

   state_t             state_q, state_d;
   logic [MAX_SYM-1:0] shreg_q, shreg_d;
   logic [LEN_W-1:0]   cnt_q, cnt_d;
   logic [MAX_SYM-1:0] pend_code_q, pend_code_d;
   logic [LEN_W-1:0]   pend_len_q, pend_len_d;
   logic               pend_v_q, pend_v_d;
   logic               data_q, data_d;
   logic               sym_valid_q, sym_valid_d;
   logic               done_q, done_d;
   logic               err_q, err_d;

   logic [MAX_SYM-1:0] len_mask;
   logic [MAX_SYM-1:0] code_masked;
   logic [MAX_SYM-1:0] sel;
   logic [MAX_SYM-1:0] shreg_shifted;
   logic               sym_out;
   logic               len_ok;
   logic               load_ok;
   logic               load_bad;
   logic               shift_ok;
   logic               finish;

   always_comb begin
      len_mask = '1;
      if (len_in < MAX_LEN) begin
         len_mask = (ONE_HOT << len_in) - ONE_HOT;
      end
   end

   assign code_masked = code_in & len_mask;
   assign len_ok      = (len_in <= MAX_LEN);
   assign load_ok     = load_i & ~pend_v_q & len_ok;
   assign load_bad    = load_i & ~pend_v_q & ~len_ok;
   assign shift_ok    = (state_q == S_ACTIVE) & shift_i & (cnt_q != '0);
   // cnt==0 in ACTIVE only arises from a zero-length word taken from the
   // pending buffer (or loaded on a finish); it completes on its own.
   assign finish      = (state_q == S_ACTIVE) &
                        ((cnt_q == '0) | (shift_i & (cnt_q == LEN_W'(1))));

   // Bits above cnt are always zero, so MSB-first picks bit cnt-1 and clears it.
   always_comb begin
      sel           = ONE_HOT << (cnt_q - LEN_W'(1));
      sym_out       = shreg_q[0];
      shreg_shifted = shreg_q >> 1;
      if (MSB_FIRST) begin
         sym_out       = |(shreg_q & sel);
         shreg_shifted = shreg_q & ~sel;
      end
   end

   always_ff @(posedge half_clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:   if (load_ok && (len_in != '0)) state_d = S_ACTIVE;
         S_ACTIVE: if (finish && !pend_v_q && !load_ok) state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_comb begin
      shreg_d     = shreg_q;
      cnt_d       = cnt_q;
      pend_code_d = pend_code_q;
      pend_len_d  = pend_len_q;
      pend_v_d    = pend_v_q;
      data_d      = data_q;
      sym_valid_d = 1'b0;
      done_d      = 1'b0;
      err_d       = load_bad;

      if (shift_ok) begin
         data_d      = sym_out;
         sym_valid_d = 1'b1;
         shreg_d     = shreg_shifted;
         cnt_d       = cnt_q - LEN_W'(1);
      end

      unique case (state_q)
         S_IDLE: begin
            if (load_ok) begin
               shreg_d = code_masked;
               cnt_d   = len_in;
               done_d  = (len_in == '0);
            end
         end
         S_ACTIVE: begin
            if (finish) begin
               done_d = 1'b1;
               if (pend_v_q) begin
                  shreg_d  = pend_code_q;
                  cnt_d    = pend_len_q;
                  pend_v_d = 1'b0;
               end else if (load_ok) begin
                  shreg_d = code_masked;
                  cnt_d   = len_in;
               end
            end else if (load_ok) begin
               pend_code_d = code_masked;
               pend_len_d  = len_in;
               pend_v_d    = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge half_clk or negedge rst) begin
      if (!rst) begin
         shreg_q     <= '0;
         cnt_q       <= '0;
         pend_code_q <= '0;
         pend_len_q  <= '0;
         pend_v_q    <= 1'b0;
         data_q      <= 1'b0;
         sym_valid_q <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         shreg_q     <= shreg_d;
         cnt_q       <= cnt_d;
         pend_code_q <= pend_code_d;
         pend_len_q  <= pend_len_d;
         pend_v_q    <= pend_v_d;
         data_q      <= data_d;
         sym_valid_q <= sym_valid_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

   assign load_rdy  = ~pend_v_q;
   assign data      = data_q;
   assign sym_valid = sym_valid_q;
   assign new_data  = shreg_q;
   assign count     = cnt_q;
   assign busy      = (state_q == S_ACTIVE);
   assign done      = done_q;
   assign err       = err_q;

endmodule

// File: tb/tb_morse_symbol_shifter.sv
// Bench for morse_symbol_shifter: one LSB-first and one MSB-first instance
// share the same stimulus. A word-level model (word, length, symbols
// emitted so far, pending word) predicts both instances every cycle.
module tb_morse_symbol_shifter;

   logic       half_clk = 1'b0;
   logic       rst      = 1'b0;
   logic [3:0] code_in  = '0;
   logic [2:0] len_in   = '0;
   logic       load_i   = 1'b0;
   logic       shift_i  = 1'b0;

   logic       rdy_l, data_l, sv_l, busy_l, done_l, err_l;
   logic [3:0] nd_l;
   logic [2:0] cnt_l;
   logic       rdy_m, data_m, sv_m, busy_m, done_m, err_m;
   logic [3:0] nd_m;
   logic [2:0] cnt_m;

   int tests = 0;
   int fails = 0;

   always #5 half_clk = ~half_clk;

   morse_symbol_shifter #(.MAX_SYM(4), .MSB_FIRST(1'b0)) u_lsb (
      .half_clk(half_clk), .rst(rst), .code_in(code_in), .len_in(len_in),
      .load_i(load_i), .shift_i(shift_i), .load_rdy(rdy_l), .data(data_l),
      .sym_valid(sv_l), .new_data(nd_l), .count(cnt_l), .busy(busy_l),
      .done(done_l), .err(err_l));

   morse_symbol_shifter #(.MAX_SYM(4), .MSB_FIRST(1'b1)) u_msb (
      .half_clk(half_clk), .rst(rst), .code_in(code_in), .len_in(len_in),
      .load_i(load_i), .shift_i(shift_i), .load_rdy(rdy_m), .data(data_m),
      .sym_valid(sv_m), .new_data(nd_m), .count(cnt_m), .busy(busy_m),
      .done(done_m), .err(err_m));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- word-level model ----------------
   int m_w, m_L, m_k, m_act, m_pw, m_pl, m_pv, m_dl, m_dm, m_sv, m_done, m_err;

   task automatic model_reset();
      m_w = 0; m_L = 0; m_k = 0; m_act = 0;
      m_pw = 0; m_pl = 0; m_pv = 0;
      m_dl = 0; m_dm = 0; m_sv = 0; m_done = 0; m_err = 0;
   endtask

   // Applies the inputs that the coming rising edge will sample.
   task automatic model_step();
      int  lenv, cw, rem;
      bit  acc, fin;
      lenv   = int'(len_in);
      cw     = int'(code_in) & ((1 << lenv) - 1);
      m_sv   = 0;
      m_done = 0;
      m_err  = (load_i && !m_pv && lenv > 4) ? 1 : 0;
      acc    = load_i && !m_pv && lenv <= 4;
      if (!m_act) begin
         if (acc) begin
            m_w = cw; m_L = lenv; m_k = 0;
            if (lenv > 0) m_act = 1;
            else m_done = 1;
         end
      end else begin
         rem = m_L - m_k;
         fin = 1'b0;
         if (shift_i && rem > 0) begin
            m_dl = (m_w >> m_k) & 1;
            m_dm = (m_w >> (m_L - 1 - m_k)) & 1;
            m_k++;
            m_sv = 1;
            fin  = (rem == 1);
         end else if (rem == 0) begin
            fin = 1'b1;
         end
         if (fin) begin
            m_done = 1;
            if (m_pv) begin
               m_w = m_pw; m_L = m_pl; m_k = 0; m_pv = 0;
            end else if (acc) begin
               m_w = cw; m_L = lenv; m_k = 0;
            end else begin
               m_act = 0;
            end
         end else if (acc) begin
            m_pw = cw; m_pl = lenv; m_pv = 1;
         end
      end
   endtask

   task automatic model_compare();
      int ndl, ndm;
      ndl = (m_w >> m_k) & 15;
      ndm = m_w & ((1 << (m_L - m_k)) - 1);
      chk("lsb.data",      data_l, m_dl);
      chk("lsb.sym_valid", sv_l,   m_sv);
      chk("lsb.new_data",  nd_l,   ndl);
      chk("lsb.count",     cnt_l,  m_L - m_k);
      chk("lsb.busy",      busy_l, m_act);
      chk("lsb.done",      done_l, m_done);
      chk("lsb.err",       err_l,  m_err);
      chk("lsb.load_rdy",  rdy_l,  !m_pv);
      chk("msb.data",      data_m, m_dm);
      chk("msb.sym_valid", sv_m,   m_sv);
      chk("msb.new_data",  nd_m,   ndm);
      chk("msb.count",     cnt_m,  m_L - m_k);
      chk("msb.busy",      busy_m, m_act);
      chk("msb.done",      done_m, m_done);
      chk("msb.err",       err_m,  m_err);
      chk("msb.load_rdy",  rdy_m,  !m_pv);
   endtask

   // Inputs only change just after a rising edge, so at the falling edge
   // they are exactly what the next rising edge will sample.
   initial begin
      model_reset();
      forever begin
         @(negedge half_clk);
         if (!rst) model_reset();
         model_compare();
         if (rst) model_step();
      end
   end

   // One cycle with the given inputs; returns just after the edge that used them.
   task automatic clk1(input logic ld, input logic [3:0] c, input logic [2:0] l, input logic sh);
      load_i = ld; code_in = c; len_in = l; shift_i = sh;
      @(posedge half_clk);
      #1;
      load_i = 1'b0; code_in = '0; len_in = '0; shift_i = 1'b0;
   endtask

   initial begin
      repeat (2) @(posedge half_clk);
      #1;
      chk("reset.data",     data_l, 0);
      chk("reset.new_data", nd_l,   0);
      chk("reset.count",    cnt_l,  0);
      chk("reset.busy",     busy_l, 0);
      chk("reset.load_rdy", rdy_l,  1);
      rst = 1'b1;
      clk1(0, 4'h0, 3'd0, 0);

      // LSB-first 0110, 4 symbols
      clk1(1, 4'b0110, 3'd4, 0);
      chk("t1.load.new_data", nd_l, 4'b0110);
      chk("t1.load.count",    cnt_l, 4);
      chk("t1.load.busy",     busy_l, 1);
      clk1(0, 4'h0, 3'd0, 1);
      chk("t1.s1.data", data_l, 0); chk("t1.s1.new_data", nd_l, 4'b0011);
      clk1(0, 4'h0, 3'd0, 1);
      chk("t1.s2.data", data_l, 1); chk("t1.s2.new_data", nd_l, 4'b0001);
      clk1(0, 4'h0, 3'd0, 1);
      chk("t1.s3.data", data_l, 1); chk("t1.s3.new_data", nd_l, 4'b0000);
      clk1(0, 4'h0, 3'd0, 1);
      chk("t1.s4.data", data_l, 0); chk("t1.s4.done", done_l, 1);
      chk("t1.s4.busy", busy_l, 0); chk("t1.s4.sym_valid", sv_l, 1);
      clk1(0, 4'h0, 3'd0, 0);
      chk("t1.after.done", done_l, 0); chk("t1.after.new_data", nd_l, 0);

      // MSB-first 011, 3 symbols
      clk1(1, 4'b0011, 3'd3, 0);
      chk("t2.load.new_data", nd_m, 4'b0011); chk("t2.load.count", cnt_m, 3);
      clk1(0, 4'h0, 3'd0, 1);
      chk("t2.s1.data", data_m, 0); chk("t2.s1.count", cnt_m, 2);
      chk("t2.s1.new_data", nd_m, 4'b0011);
      clk1(0, 4'h0, 3'd0, 1);
      chk("t2.s2.data", data_m, 1); chk("t2.s2.count", cnt_m, 1);
      chk("t2.s2.new_data", nd_m, 4'b0001);
      clk1(0, 4'h0, 3'd0, 1);
      chk("t2.s3.data", data_m, 1); chk("t2.s3.count", cnt_m, 0);
      chk("t2.s3.new_data", nd_m, 4'b0000); chk("t2.s3.done", done_m, 1);
      clk1(0, 4'h0, 3'd0, 0);

      // back-to-back: A=10 (len 2), B=1 (len 1) queued while shifting
      clk1(1, 4'b0010, 3'd2, 0);
      clk1(1, 4'b0001, 3'd1, 1);
      chk("t3.q.data", data_l, 0); chk("t3.q.load_rdy", rdy_l, 0);
      clk1(0, 4'h0, 3'd0, 1);
      chk("t3.a2.data", data_l, 1); chk("t3.a2.done", done_l, 1);
      chk("t3.a2.busy", busy_l, 1); chk("t3.a2.count", cnt_l, 1);
      chk("t3.a2.load_rdy", rdy_l, 1);
      clk1(0, 4'h0, 3'd0, 1);
      chk("t3.b1.data", data_l, 1); chk("t3.b1.done", done_l, 1);
      chk("t3.b1.busy", busy_l, 0);
      clk1(0, 4'h0, 3'd0, 0);

      // illegal length, then zero length
      clk1(1, 4'b1111, 3'd5, 0);
      chk("t4.err", err_l, 1); chk("t4.err.busy", busy_l, 0);
      chk("t4.err.count", cnt_l, 0);
      clk1(0, 4'h0, 3'd0, 0);
      chk("t4.err.clear", err_l, 0);
      clk1(1, 4'b1111, 3'd0, 0);
      chk("t4.len0.done", done_l, 1); chk("t4.len0.sym_valid", sv_l, 0);
      chk("t4.len0.busy", busy_l, 0);
      clk1(0, 4'h0, 3'd0, 0);

      // shift held in IDLE, then load+shift together
      repeat (3) begin
         clk1(0, 4'h0, 3'd0, 1);
         chk("t6.idle.sym_valid", sv_l, 0);
         chk("t6.idle.data", data_l, 1);
      end
      clk1(1, 4'b0101, 3'd3, 1);
      chk("t6.ls.busy", busy_l, 1); chk("t6.ls.count", cnt_l, 3);
      chk("t6.ls.new_data", nd_l, 4'b0101); chk("t6.ls.sym_valid", sv_l, 0);
      repeat (3) clk1(0, 4'h0, 3'd0, 1);
      chk("t6.end.done", done_l, 1); chk("t6.end.data", data_l, 1);
      clk1(0, 4'h0, 3'd0, 0);

      // zero-length word waiting in the pending buffer
      clk1(1, 4'b0001, 3'd1, 0);
      clk1(1, 4'b0000, 3'd0, 0);
      chk("p0.load_rdy", rdy_l, 0);
      clk1(0, 4'h0, 3'd0, 1);
      chk("p0.d1.done", done_l, 1); chk("p0.d1.busy", busy_l, 1);
      chk("p0.d1.count", cnt_l, 0);
      clk1(0, 4'h0, 3'd0, 0);
      chk("p0.d2.done", done_l, 1); chk("p0.d2.busy", busy_l, 0);
      clk1(0, 4'h0, 3'd0, 0);
      chk("p0.after.done", done_l, 0);

      // asynchronous reset mid-word
      clk1(1, 4'b1011, 3'd4, 0);
      clk1(0, 4'h0, 3'd0, 1);
      clk1(0, 4'h0, 3'd0, 1);
      #2;
      rst = 1'b0;
      #1;
      chk("t5.rst.data",      data_l, 0);
      chk("t5.rst.sym_valid", sv_l,   0);
      chk("t5.rst.new_data",  nd_l,   0);
      chk("t5.rst.count",     cnt_l,  0);
      chk("t5.rst.busy",      busy_l, 0);
      chk("t5.rst.done",      done_l, 0);
      chk("t5.rst.err",       err_l,  0);
      chk("t5.rst.load_rdy",  rdy_l,  1);
      @(posedge half_clk);
      #1;
      rst = 1'b1;
      clk1(0, 4'h0, 3'd0, 0);
      chk("t5.post.done", done_l, 0); chk("t5.post.busy", busy_l, 0);
      repeat (2) clk1(0, 4'h0, 3'd0, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
